// File: rtl/hack_cpu_core.sv
// Multi-cycle Hack CPU: fetches over a req/valid port, executes A/C-instructions,
// and accesses data memory over a req/ready handshake with one request outstanding.
module hack_cpu_core #(
    parameter int                     PC_WIDTH = 15,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                instr_req,
    output logic [PC_WIDTH-1:0] pc,
    input  logic                instr_valid,
    input  logic [15:0]         instr,
    output logic                mem_req,
    output logic                writeM,
    output logic [PC_WIDTH-1:0] addressM,
    output logic [15:0]         outM,
    input  logic [15:0]         inM,
    input  logic                mem_ready,
    output logic [15:0]         a_reg,
    output logic [15:0]         d_reg
);

    typedef enum logic [2:0] {
        S_FETCH_IDLE,
        S_FETCH,
        S_EXEC,
        S_READ,
        S_WRITE
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         a_q, a_d;
    logic [15:0]         d_q, d_d;
    logic [15:0]         ir_q, ir_d;
    logic [15:0]         out_q, out_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] addr_q, addr_d;
    logic                ireq_q, ireq_d;
    logic                mreq_q, mreq_d;
    logic                wr_q, wr_d;

    logic                compute;
    logic [15:0]         alu_y;
    logic [15:0]         alu_out;
    logic                alu_zr, alu_ng;
    logic                jump;

    // Hack ALU: {zx,nx,zy,ny,f,no} applied to x and y.
    function automatic logic [15:0] hack_alu(input logic [15:0] x_in, input logic [15:0] y_in,
                                             input logic [5:0] ctl);
        logic [15:0] x, y, r;
        x = ctl[5] ? 16'h0000 : x_in;
        x = ctl[4] ? ~x : x;
        y = ctl[3] ? 16'h0000 : y_in;
        y = ctl[2] ? ~y : y;
        r = ctl[1] ? x + y : x & y;
        return ctl[0] ? ~r : r;
    endfunction

    // Memory operand is consumed on the same edge it arrives, so READ costs one cycle.
    assign alu_y   = (state_q == S_READ) ? inM : a_q;
    assign alu_out = hack_alu(d_q, alu_y, ir_q[11:6]);
    assign alu_zr  = (alu_out == 16'h0000);
    assign alu_ng  = alu_out[15];
    assign jump    = (ir_q[2] & alu_ng) | (ir_q[1] & alu_zr) | (ir_q[0] & ~alu_ng & ~alu_zr);

    always_comb begin
        // NOTE: every next-state value gets a default first so no path can infer a latch.
        state_d = state_q;
        a_d     = a_q;
        d_d     = d_q;
        ir_d    = ir_q;
        out_d   = out_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        ireq_d  = ireq_q;
        mreq_d  = mreq_q;
        wr_d    = wr_q;
        compute = 1'b0;

        case (state_q)
            S_FETCH_IDLE: begin
                state_d = S_FETCH;
                ireq_d  = 1'b1;
            end
            S_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    ireq_d  = 1'b0;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                // Address is frozen here so a later write uses the pre-instruction A.
                addr_d = a_q[PC_WIDTH-1:0];
                if (!ir_q[15]) begin
                    a_d     = ir_q;
                    pc_d    = pc_q + 1'b1;
                    state_d = S_FETCH;
                    ireq_d  = 1'b1;
                end else if (ir_q[12]) begin
                    state_d = S_READ;
                    mreq_d  = 1'b1;
                    wr_d    = 1'b0;
                end else begin
                    compute = 1'b1;
                end
            end
            S_READ: begin
                if (mem_ready) begin
                    compute = 1'b1;
                    mreq_d  = 1'b0;
                end
            end
            S_WRITE: begin
                if (mem_ready) begin
                    mreq_d  = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_FETCH;
                    ireq_d  = 1'b1;
                end
            end
            default: state_d = S_FETCH_IDLE;
        endcase

        if (compute) begin
            if (ir_q[5]) a_d = alu_out;
            if (ir_q[4]) d_d = alu_out;
            pc_d = jump ? a_q[PC_WIDTH-1:0] : pc_q + 1'b1;
            if (ir_q[3]) begin
                out_d   = alu_out;
                state_d = S_WRITE;
                mreq_d  = 1'b1;
                wr_d    = 1'b1;
            end else begin
                state_d = S_FETCH;
                ireq_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH_IDLE;
            a_q     <= '0;
            d_q     <= '0;
            ir_q    <= '0;
            out_q   <= '0;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            ireq_q  <= 1'b0;
            mreq_q  <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q <= state_d;
            a_q     <= a_d;
            d_q     <= d_d;
            ir_q    <= ir_d;
            out_q   <= out_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            ireq_q  <= ireq_d;
            mreq_q  <= mreq_d;
            wr_q    <= wr_d;
        end
    end

    assign instr_req = ireq_q;
    assign pc        = pc_q;
    assign mem_req   = mreq_q;
    assign writeM    = wr_q;
    assign addressM  = addr_q;
    assign outM      = out_q;
    assign a_reg     = a_q;
    assign d_reg     = d_q;

endmodule

// File: tb/tb_hack_cpu_core.sv
// Directed bench for hack_cpu_core: the bench plays ROM and data memory and
// checks registers, handshakes and cycle counts against hand-computed values.
module tb_hack_cpu_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_req;
    logic [14:0] pc;
    logic        instr_valid = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        mem_req;
    logic        writeM;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic [15:0] inM = 16'h0000;
    logic        mem_ready = 1'b0;
    logic [15:0] a_reg;
    logic [15:0] d_reg;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int c0      = 0;

    hack_cpu_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr_req  (instr_req),
        .pc         (pc),
        .instr_valid(instr_valid),
        .instr      (instr),
        .mem_req    (mem_req),
        .writeM     (writeM),
        .addressM   (addressM),
        .outM       (outM),
        .inM        (inM),
        .mem_ready  (mem_ready),
        .a_reg      (a_reg),
        .d_reg      (d_reg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    // Called at a negedge; supplies one instruction as soon as instr_req is seen.
    task automatic feed(input logic [15:0] w);
        int n = 0;
        while (!instr_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_req) begin
            check("fetch_timeout", {31'd0, instr_req}, 32'd1);
        end else begin
            instr       = w;
            instr_valid = 1'b1;
            @(negedge clk);
            instr_valid = 1'b0;
        end
    endtask

    // Called at a negedge; serves one data access after wait_cycles and checks it.
    task automatic serve(input string tag, input int wait_cycles, input logic [15:0] rdata,
                         input logic exp_wr, input logic [14:0] exp_addr,
                         input logic [15:0] exp_data);
        int n = 0;
        int held = 0;
        while (!mem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        check({tag, "_wr"}, {31'd0, writeM}, {31'd0, exp_wr});
        check({tag, "_addr"}, {17'd0, addressM}, {17'd0, exp_addr});
        if (exp_wr) check({tag, "_data"}, {16'd0, outM}, {16'd0, exp_data});
        for (int i = 0; i < wait_cycles; i++) begin
            if (mem_req) held++;
            @(negedge clk);
        end
        if (mem_req) held++;
        inM       = rdata;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check({tag, "_held"}, held, wait_cycles + 1);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ireq", {31'd0, instr_req}, 32'd0);
        check("rst_mreq", {31'd0, mem_req}, 32'd0);
        check("rst_pc", {17'd0, pc}, 32'd0);
        check("rst_a", {16'd0, a_reg}, 32'd0);
        check("rst_d", {16'd0, d_reg}, 32'd0);
        rst_n = 1'b1;
        c0 = cyc;
        check("rel_ireq0", {31'd0, instr_req}, 32'd0);
        @(posedge clk);
        #1 check("rel_ireq1", {31'd0, instr_req}, 32'd1);
        @(negedge clk);

        // @5; D=A; @3; D=D+A at zero wait
        feed(16'h0005);
        feed(16'hEC10);
        feed(16'h0003);
        feed(16'hE090);
        check("prog_pc_mid", {17'd0, pc}, 32'd3);
        check("prog_d_mid", {16'd0, d_reg}, 32'h5);
        @(negedge clk);
        check("prog_d", {16'd0, d_reg}, 32'h8);
        check("prog_a", {16'd0, a_reg}, 32'h3);
        check("prog_pc", {17'd0, pc}, 32'd4);
        check("prog_cycles", cyc - c0, 32'd9);

        // @0; M=D with three wait cycles
        feed(16'h0000);
        feed(16'hE308);
        serve("wr", 3, 16'h0000, 1'b1, 15'h0000, 16'h0008);
        check("wr_pc", {17'd0, pc}, 32'd6);
        check("wr_mreq_done", {31'd0, mem_req}, 32'd0);

        // @2; D=M
        feed(16'h0002);
        feed(16'hFC10);
        serve("rd", 0, 16'hFFF1, 1'b0, 15'h0002, 16'h0000);
        check("rd_d", {16'd0, d_reg}, 32'hFFF1);
        check("rd_pc", {17'd0, pc}, 32'd8);

        // D negative: @9; D;JLT taken
        feed(16'h0009);
        feed(16'hE304);
        @(negedge clk);
        check("jlt_taken_pc", {17'd0, pc}, 32'd9);

        // D=8: @8; D=A; @9; D;JLT not taken
        feed(16'h0008);
        feed(16'hEC10);
        feed(16'h0009);
        feed(16'hE304);
        @(negedge clk);
        check("jlt_nt_d", {16'd0, d_reg}, 32'h8);
        check("jlt_nt_pc", {17'd0, pc}, 32'd13);

        // @0x7FFF; 0;JMP, then wrap on the next A-instruction
        feed(16'h7FFF);
        feed(16'hEA87);
        @(negedge clk);
        check("jmp_pc", {17'd0, pc}, 32'h7FFF);
        check("jmp_d", {16'd0, d_reg}, 32'h8);
        feed(16'h0011);
        @(negedge clk);
        check("wrap_pc", {17'd0, pc}, 32'd0);
        check("wrap_a", {16'd0, a_reg}, 32'h11);

        // A=1;JMP: jump uses old A while A loads in the same edge
        feed(16'hEFE7);
        @(negedge clk);
        check("dstA_jmp_pc", {17'd0, pc}, 32'h11);
        check("dstA_jmp_a", {16'd0, a_reg}, 32'h1);

        // Stray mem_ready while fetching with mem_req low
        check("stray_in_fetch", {31'd0, instr_req}, 32'd1);
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        mem_ready = 1'b0;
        check("stray_m_mreq", {31'd0, mem_req}, 32'd0);
        check("stray_m_ireq", {31'd0, instr_req}, 32'd1);
        check("stray_m_pc", {17'd0, pc}, 32'h11);
        check("stray_m_a", {16'd0, a_reg}, 32'h1);
        check("stray_m_d", {16'd0, d_reg}, 32'h8);

        // M=D, then stray instr_valid during the WRITE stall
        feed(16'hE308);
        for (int n = 0; n < 50 && !mem_req; n++) @(negedge clk);
        check("stray_i_inwrite", {31'd0, mem_req}, 32'd1);
        instr       = 16'h0123;
        instr_valid = 1'b1;
        repeat (2) @(negedge clk);
        instr_valid = 1'b0;
        check("stray_i_ireq", {31'd0, instr_req}, 32'd0);
        check("stray_i_mreq", {31'd0, mem_req}, 32'd1);
        check("stray_i_wr", {31'd0, writeM}, 32'd1);
        check("stray_i_a", {16'd0, a_reg}, 32'h1);
        check("stray_i_pc", {17'd0, pc}, 32'h12);

        // Reset lands mid-WRITE
        #2 rst_n = 1'b0;
        #1;
        check("midrst_mreq", {31'd0, mem_req}, 32'd0);
        check("midrst_wr", {31'd0, writeM}, 32'd0);
        check("midrst_a", {16'd0, a_reg}, 32'd0);
        check("midrst_d", {16'd0, d_reg}, 32'd0);
        check("midrst_pc", {17'd0, pc}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("midrst_rel0", {31'd0, instr_req}, 32'd0);
        @(posedge clk);
        #1 check("midrst_rel1", {31'd0, instr_req}, 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
